// File: rtl/uart_tx_buffered_pkg.sv
// Shared 8N1 UART definitions: FSM state encoding, frame constants and baud divisor helper.
// Imported by both the transmit and receive paths.
package uart_tx_buffered_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_buffered_sync_fifo.sv
// Single-clock FIFO with occupancy count; full/empty decoded from count.
// Write acceptance is judged on the count before any same-cycle read.
module uart_tx_buffered_sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_acc;
    logic             rd_acc;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign wr_acc  = wr_en && !full;
    assign rd_acc  = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: bytes queue in a FIFO and are shifted out LSB-first on tx.
// tx and tx_done are registered, so the line trails the FSM state by one clock.
module uart_tx_buffered
    import uart_tx_buffered_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9_600,
    parameter int DEPTH    = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [7:0]             wr_data,
    output logic                   tx,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   busy,
    output logic                   tx_done,
    output logic                   overflow,
    output uart_state_t            state
);

    localparam int CPB = clks_per_bit(CLK_FREQ, BAUD);
    localparam int BW  = (CPB > 1) ? $clog2(CPB) : 1;

    localparam logic [BW-1:0] BAUD_LAST = BW'(CPB - 1);
    localparam logic [2:0]    DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

    uart_state_t   cur_state;
    uart_state_t   next_state;
    logic [BW-1:0] baud_cnt;
    logic [BW-1:0] baud_next;
    logic [2:0]    bit_idx;
    logic [2:0]    bit_next;
    logic [7:0]    shift;
    logic [7:0]    shift_next;
    logic [7:0]    head;
    logic          tx_next;
    logic          done_next;
    logic          pop;
    logic          bit_end;

    uart_tx_buffered_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    assign state   = cur_state;
    assign busy    = (cur_state != ST_IDLE) || !empty;
    assign bit_end = (baud_cnt == BAUD_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_state <= ST_IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            tx        <= 1'b1;
            tx_done   <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            cur_state <= next_state;
            baud_cnt  <= baud_next;
            bit_idx   <= bit_next;
            shift     <= shift_next;
            tx        <= tx_next;
            tx_done   <= done_next;
            overflow  <= overflow | (wr_en & full);
        end
    end

    // Baud counter reloads at every bit boundary so bit widths never drift.
    always_comb begin
        next_state = cur_state;
        baud_next  = baud_cnt;
        bit_next   = bit_idx;
        shift_next = shift;
        tx_next    = 1'b1;
        done_next  = 1'b0;
        pop        = 1'b0;
        case (cur_state)
            ST_IDLE: begin
                baud_next = '0;
                bit_next  = '0;
                if (!empty) begin
                    pop        = 1'b1;
                    shift_next = head;
                    next_state = ST_START;
                end
            end
            ST_START: begin
                tx_next = 1'b0;
                if (bit_end) begin
                    baud_next  = '0;
                    bit_next   = '0;
                    next_state = ST_DATA;
                end else begin
                    baud_next = baud_cnt + BW'(1);
                end
            end
            ST_DATA: begin
                tx_next = shift[0];
                if (bit_end) begin
                    baud_next  = '0;
                    shift_next = {1'b0, shift[7:1]};
                    if (bit_idx == DATA_LAST) begin
                        bit_next   = '0;
                        next_state = ST_STOP;
                    end else begin
                        bit_next = bit_idx + 3'd1;
                    end
                end else begin
                    baud_next = baud_cnt + BW'(1);
                end
            end
            ST_STOP: begin
                tx_next = 1'b1;
                if (bit_end) begin
                    baud_next = '0;
                    if (bit_idx == STOP_LAST) begin
                        bit_next   = '0;
                        done_next  = 1'b1;
                        next_state = ST_IDLE;
                    end else begin
                        bit_next = bit_idx + 3'd1;
                    end
                end else begin
                    baud_next = baud_cnt + BW'(1);
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

endmodule
